// File: rtl/execute_pipe.sv
// Y86 execute stage: one-deep registered output with valid/ready handshake,
// ALU, condition-code register and branch/cmov condition evaluation.
module execute_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       icode_i,
  input  logic [3:0]       ifun_i,
  input  logic [WIDTH-1:0] valA_i,
  input  logic [WIDTH-1:0] valB_i,
  input  logic [WIDTH-1:0] valC_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             set_cc_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] valE_o,
  output logic             Cnd_o,
  output logic             err_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [2:0]       cc_o
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;

  localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(WIDTH / 8);
  localparam logic [2:0]       CC_RESET   = 3'b100;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] vale_q, vale_d;
  logic             cnd_q, cnd_d;
  logic             err_q, err_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       cc_q, cc_d;

  logic             accept;
  logic             exe_err;
  logic [WIDTH-1:0] exe_vale;
  logic             exe_cnd;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic             cond_met;
  logic             zf_q, sf_q, of_q;

  assign in_ready_o = !rst_i && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  assign zf_q = cc_q[2];
  assign sf_q = cc_q[1];
  assign of_q = cc_q[0];

  always_comb begin
    exe_err = 1'b0;
    if (icode_i > I_POPQ) begin
      exe_err = 1'b1;
    end else if (icode_i == I_OPQ && ifun_i > F_XOR) begin
      exe_err = 1'b1;
    end else if ((icode_i == I_RRMOVQ || icode_i == I_JXX) && ifun_i > 4'h6) begin
      exe_err = 1'b1;
    end
  end

  // OF is defined on the operand order valB op valA, matching subq semantics.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (ifun_i)
      F_ADD: begin
        alu_res = valB_i + valA_i;
        alu_of  = (valB_i[WIDTH-1] == valA_i[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != valB_i[WIDTH-1]);
      end
      F_SUB: begin
        alu_res = valB_i - valA_i;
        alu_of  = (valB_i[WIDTH-1] != valA_i[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != valB_i[WIDTH-1]);
      end
      F_AND:   alu_res = valB_i & valA_i;
      F_XOR:   alu_res = valB_i ^ valA_i;
      default: alu_res = '0;
    endcase
  end

  // Conditions read the CC register as it stood before this edge.
  always_comb begin
    cond_met = 1'b0;
    case (ifun_i)
      4'h0:    cond_met = 1'b1;
      4'h1:    cond_met = (sf_q ^ of_q) | zf_q;
      4'h2:    cond_met = sf_q ^ of_q;
      4'h3:    cond_met = zf_q;
      4'h4:    cond_met = !zf_q;
      4'h5:    cond_met = !(sf_q ^ of_q);
      4'h6:    cond_met = !(sf_q ^ of_q) && !zf_q;
      default: cond_met = 1'b0;
    endcase
  end

  always_comb begin
    exe_vale = '0;
    exe_cnd  = 1'b1;
    case (icode_i)
      I_RRMOVQ:          exe_vale = valA_i;
      I_IRMOVQ:          exe_vale = valC_i;
      I_RMMOVQ, I_MRMOVQ: exe_vale = valB_i + valC_i;
      I_OPQ:             exe_vale = alu_res;
      I_CALL, I_PUSHQ:   exe_vale = valB_i - STACK_STEP;
      I_RET, I_POPQ:     exe_vale = valB_i + STACK_STEP;
      I_HALT, I_NOP, I_JXX: exe_vale = '0;
      default:           exe_vale = '0;
    endcase
    if (icode_i == I_RRMOVQ || icode_i == I_JXX) begin
      exe_cnd = cond_met;
    end
    if (exe_err) begin
      exe_vale = '0;
      exe_cnd  = 1'b0;
    end
  end

  // Flush wins over backpressure; a simultaneous drain and accept reloads with no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    vale_d      = vale_q;
    cnd_d       = cnd_q;
    err_d       = err_q;
    tag_d       = tag_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      vale_d      = exe_vale;
      cnd_d       = exe_cnd;
      err_d       = exe_err;
      tag_d       = tag_i;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    cc_d = cc_q;
    if (accept && set_cc_i && icode_i == I_OPQ && !exe_err) begin
      cc_d = {(alu_res == '0), alu_res[WIDTH-1], alu_of};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      vale_q      <= '0;
      cnd_q       <= 1'b0;
      err_q       <= 1'b0;
      tag_q       <= '0;
      cc_q        <= CC_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      vale_q      <= vale_d;
      cnd_q       <= cnd_d;
      err_q       <= err_d;
      tag_q       <= tag_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign valE_o      = vale_q;
  assign Cnd_o       = cnd_q;
  assign err_o       = err_q;
  assign tag_o       = tag_q;
  assign cc_o        = cc_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: hand-computed vectors checked with
// immediate assertions after each clock edge.
module tb_execute_pipe;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [3:0]  icode_i;
   logic [3:0]  ifun_i;
   logic [63:0] valA_i;
   logic [63:0] valB_i;
   logic [63:0] valC_i;
   logic [7:0]  tag_i;
   logic        set_cc_i;
   logic        flush_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [63:0] valE_o;
   logic        Cnd_o;
   logic        err_o;
   logic [7:0]  tag_o;
   logic [2:0]  cc_o;

   int checks = 0;
   int errors = 0;

   execute_pipe #(.WIDTH(64), .TAG_W(8)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .icode_i     (icode_i),
      .ifun_i      (ifun_i),
      .valA_i      (valA_i),
      .valB_i      (valB_i),
      .valC_i      (valC_i),
      .tag_i       (tag_i),
      .set_cc_i    (set_cc_i),
      .flush_i     (flush_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .valE_o      (valE_o),
      .Cnd_o       (Cnd_o),
      .err_o       (err_o),
      .tag_o       (tag_o),
      .cc_o        (cc_o)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk_i = ~clk_i;

   // Drive one instruction slot, then advance past the next rising edge.
   task automatic applyStimulus(input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] c, input logic [7:0] tag,
                                input logic valid, input logic setcc,
                                input logic flush, input logic ready);
      icode_i     = icode;
      ifun_i      = ifun;
      valA_i      = a;
      valB_i      = b;
      valC_i      = c;
      tag_i       = tag;
      in_valid_i  = valid;
      set_cc_i    = setcc;
      flush_i     = flush;
      out_ready_i = ready;
      @(posedge clk_i);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string name, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
      end
   endtask

   // Directed sequence covering reset, ALU/flags, branches, backpressure, flush, errors.
   initial begin
      rst_i = 1'b1;
      applyStimulus(4'h3, 4'h0, 64'd0, 64'd0, 64'd55, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("rst_valid", {63'd0, out_valid_o}, 64'd0);
      checkOutput("rst_valE", valE_o, 64'd0);
      checkOutput("rst_cnd", {63'd0, Cnd_o}, 64'd0);
      checkOutput("rst_err", {63'd0, err_o}, 64'd0);
      checkOutput("rst_tag", {56'd0, tag_o}, 64'd0);
      checkOutput("rst_cc", {61'd0, cc_o}, 64'd4);
      checkOutput("rst_in_ready", {63'd0, in_ready_o}, 64'd0);
      rst_i = 1'b0;

      applyStimulus(4'h3, 4'h0, 64'd0, 64'd0, 64'd100, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("irmovq_valid", {63'd0, out_valid_o}, 64'd1);
      checkOutput("irmovq_valE", valE_o, 64'd100);
      checkOutput("irmovq_cnd", {63'd0, Cnd_o}, 64'd1);
      checkOutput("irmovq_cc", {61'd0, cc_o}, 64'd4);
      checkOutput("irmovq_tag", {56'd0, tag_o}, 64'h01);

      applyStimulus(4'h6, 4'h0, 64'd200, 64'd100, 64'd0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("addq_valE", valE_o, 64'd300);
      checkOutput("addq_cc", {61'd0, cc_o}, 64'd0);
      applyStimulus(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("je_notaken", {63'd0, Cnd_o}, 64'd0);
      checkOutput("je_valE", valE_o, 64'd0);
      applyStimulus(4'h6, 4'h1, 64'd200, 64'd200, 64'd0, 8'h04, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("subq_valE", valE_o, 64'd0);
      checkOutput("subq_cc", {61'd0, cc_o}, 64'd4);
      applyStimulus(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 8'h05, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("je_taken", {63'd0, Cnd_o}, 64'd1);

      applyStimulus(4'hA, 4'h0, 64'd0, 64'd208, 64'd0, 8'h06, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("pushq_valE", valE_o, 64'd200);
      applyStimulus(4'hB, 4'h0, 64'd0, 64'd200, 64'd0, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("popq_valE", valE_o, 64'd208);
      applyStimulus(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0,
                    8'h08, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("addq_ovf_valE", valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
      checkOutput("addq_ovf_cc", {61'd0, cc_o}, 64'd3);
      applyStimulus(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 8'h09, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("jl_notaken", {63'd0, Cnd_o}, 64'd0);
      applyStimulus(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 8'h0A, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("jg_taken", {63'd0, Cnd_o}, 64'd1);
      applyStimulus(4'h4, 4'h0, 64'd0, 64'd16, 64'd24, 8'h0B, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("rmmovq_valE", valE_o, 64'd40);
      applyStimulus(4'h2, 4'h4, 64'd77, 64'd0, 64'd0, 8'h0C, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("cmovne_valE", valE_o, 64'd77);
      checkOutput("cmovne_cnd", {63'd0, Cnd_o}, 64'd1);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
         checkOutput("hold_valid", {63'd0, out_valid_o}, 64'd1);
         checkOutput("hold_valE", valE_o, 64'd77);
         checkOutput("hold_tag", {56'd0, tag_o}, 64'h0C);
         checkOutput("hold_in_ready", {63'd0, in_ready_o}, 64'd0);
         checkOutput("hold_cc", {61'd0, cc_o}, 64'd3);
      end
      applyStimulus(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("drain1_valE", valE_o, 64'd2);
      checkOutput("drain1_tag", {56'd0, tag_o}, 64'h11);
      checkOutput("drain1_cc", {61'd0, cc_o}, 64'd0);
      applyStimulus(4'h3, 4'h0, 64'd0, 64'd0, 64'd7, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("drain2_valE", valE_o, 64'd7);
      checkOutput("drain2_tag", {56'd0, tag_o}, 64'h22);
      applyStimulus(4'h3, 4'h0, 64'd0, 64'd0, 64'd9, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("drain_empty", {63'd0, out_valid_o}, 64'd0);

      applyStimulus(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("nocc_valE", valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
      checkOutput("nocc_cc", {61'd0, cc_o}, 64'd0);

      applyStimulus(4'h6, 4'h1, 64'd0, 64'd0, 64'd0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("flush_valid", {63'd0, out_valid_o}, 64'd0);
      checkOutput("flush_cc", {61'd0, cc_o}, 64'd0);

      applyStimulus(4'hC, 4'h0, 64'd0, 64'd0, 64'd5, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("badicode_valid", {63'd0, out_valid_o}, 64'd1);
      checkOutput("badicode_err", {63'd0, err_o}, 64'd1);
      checkOutput("badicode_valE", valE_o, 64'd0);
      checkOutput("badicode_cnd", {63'd0, Cnd_o}, 64'd0);
      applyStimulus(4'h6, 4'h4, 64'd0, 64'd0, 64'd0, 8'h67, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("badopq_err", {63'd0, err_o}, 64'd1);
      checkOutput("badopq_cc", {61'd0, cc_o}, 64'd0);
      applyStimulus(4'h2, 4'h7, 64'd9, 64'd0, 64'd0, 8'h68, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("badcmov_err", {63'd0, err_o}, 64'd1);
      checkOutput("badcmov_valE", valE_o, 64'd0);
      applyStimulus(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 8'h69, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("nop_err", {63'd0, err_o}, 64'd0);

      applyStimulus(4'h3, 4'h0, 64'd0, 64'd0, 64'd3, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("prerst_valid", {63'd0, out_valid_o}, 64'd1);
      rst_i = 1'b1;
      applyStimulus(4'h3, 4'h0, 64'd0, 64'd0, 64'd4, 8'h78, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("midrst_valid", {63'd0, out_valid_o}, 64'd0);
      checkOutput("midrst_cc", {61'd0, cc_o}, 64'd4);
      checkOutput("midrst_valE", valE_o, 64'd0);
      rst_i = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 Parameter WIDTH, default 64, datapath width in bits; legal values 16, 32, 64.
REQ-002 Parameter TAG_W, default 8, width of the sideband tag carried alongside each instruction.
REQ-003 clk_i  input  1  single clock; all state SHALL change only on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 in_valid_i  input  1  the input instruction is valid.
REQ-006 in_ready_o  output  1  the block can accept an input this cycle.
REQ-007 icode_i, ifun_i  input  4 each  Y86 instruction code and function code.
REQ-008 valA_i, valB_i, valC_i  input  WIDTH  operands, two's complement.
REQ-009 tag_i  input  TAG_W  opaque sideband, passed through unchanged.
REQ-010 set_cc_i  input  1  CC update enable; low suppresses all CC writes.
REQ-011 flush_i  input  1  drops the held output and the input offered this cycle.
REQ-012 out_valid_o  output  1  the output register holds a result.
REQ-013 out_ready_i  input  1  downstream accepts the result.
REQ-014 valE_o  output  WIDTH  execute result.
REQ-015 Cnd_o  output  1  condition result for jXX/cmovXX; 1 for all other icodes.
REQ-016 err_o  output  1  invalid icode or invalid ifun.
REQ-017 tag_o  output  TAG_W  tag of the held result.
REQ-018 cc_o  output  3  live CC register, bits {ZF,SF,OF}.

Function
REQ-019 Handshake: in_ready_o = !out_valid_o || out_ready_i; an input is accepted when in_valid_i && in_ready_o && !flush_i.
REQ-020 Latency: an input accepted in cycle N SHALL appear on the outputs, with out_valid_o=1, in cycle N+1.
REQ-021 Output hold: while out_valid_o && !out_ready_i, all outputs SHALL stay stable.
REQ-022 Out_valid_o drop: out_valid_o SHALL clear after a handshake that has no simultaneous accept.
REQ-023 valE, by icode:
- 2 (rrmovq/cmovXX): valA.
- 3 (irmovq): valC.
- 4, 5 (rmmovq/mrmovq): valB+valC.
- 6 (OPq): valB op valA, with ifun 0 add, 1 sub (valB−valA), 2 and, 3 xor.
- 8, A (call/pushq): valB−WIDTH/8.
- 9, B (ret/popq): valB+WIDTH/8.
- 0, 1, 7 (halt/nop/jXX): 0.
REQ-024 Arithmetic: all arithmetic SHALL be modulo 2^WIDTH.
REQ-025 Flags for OPq:
- ZF = (result == 0).
- SF = result MSB.
- OF for add = operands have the same sign and the result sign differs.
- OF for sub = valB and valA have different signs and the result sign differs from valB.
- OF for and/xor = 0.
REQ-026 CC write: the CC register SHALL update at the accepting edge only for an accepted, valid OPq with set_cc_i=1.
REQ-027 Cnd source: Cnd is computed from the CC register value before the accepting edge, so an OPq followed by a jXX in the next cycle sees the updated CC.
REQ-028 Cnd by ifun (icode 2 and 7):
- 0: 1.
- 1 (le): (SF^OF)|ZF.
- 2 (l): SF^OF.
- 3 (e): ZF.
- 4 (ne): !ZF.
- 5 (ge): !(SF^OF).
- 6 (g): !(SF^OF)&!ZF.
REQ-029 err_o=1 when:
- icode > B;
- icode 6 with ifun > 3;
- icode 2 or 7 with ifun > 6.
On error, valE_o=0, Cnd_o=0, and CC is not written.
REQ-030 Flush: flush_i=1 SHALL clear out_valid_o at the next edge, even if out_ready_i=0. The input offered that cycle is not accepted and does not write CC.
REQ-031 Simultaneous handshake and accept: the held result is consumed and the new result loaded at the same edge, so out_valid_o stays 1 with no bubble.

Reset
REQ-032 rst_i=1 at a rising edge SHALL force the following, overriding all other inputs including mid-transfer:
- out_valid_o=0, valE_o=0, Cnd_o=0, err_o=0, tag_o=0;
- cc_o=3'b100 (ZF=1, SF=0, OF=0).
REQ-033 While rst_i=1, in_ready_o SHALL be 0 and no input is accepted.

Verification
REQ-034 Reset, then irmovq (3/0, valC=100): next cycle valE_o=100, Cnd_o=1, cc_o=100.
REQ-035 Flag update and conditional jump, run back-to-back:
- addq (6/0, valA=200, valB=100): valE_o=300, cc_o=000.
- Then je (7/3): Cnd_o=0.
- Then subq (6/1, valA=200, valB=200): valE_o=0, cc_o=100.
- Then je: Cnd_o=1.
REQ-036 WIDTH=64, stack and overflow:
- pushq (A/0, valB=208): valE_o=200.
- popq (B/0, valB=200): valE_o=208.
- addq with valA=valB=0x7FFF_FFFF_FFFF_FFFF: cc_o=011.
REQ-037 Backpressure and set_cc:
- Hold out_ready_i=0 for 3 cycles with in_valid_i=1: outputs stable, in_ready_o=0, cc_o unchanged.
- Release: results drain in order, with no loss and no duplication.
- OPq with set_cc_i=0 leaves cc_o unchanged.
REQ-038 Flush with a held result and an offered OPq, out_ready_i=0: next cycle out_valid_o=0 and cc_o unchanged. Illegal icode C: err_o=1, valE_o=0.
REQ-039 Reset asserted while out_valid_o=1 and out_ready_i=0: next cycle out_valid_o=0, cc_o=100.
